move_sequencer: RTL

- Command scheduler in front of the motion core (jerk/acceleration/speed planner plus step generators).
- Buffers G-code move commands (feed speed plus five signed axis step counts) in a FIFO.
- Issues one move at a time: drives the core's start level and move data, waits for the core's finish, and handles end-stop errors.
- Flushes the queue on fault and reports progress to the G-code parser and host interface.

---
 rtl/move_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Move command scheduler: buffers moves in a FIFO and hands them to the motion core one at a time.
// Optional watchdog per move: define MOVE_SEQ_TIMEOUT_EN.
module move_sequencer #(
  parameter int          DEPTH          = 8,
  parameter int          ADDR_W         = 3,
  parameter int          GAP_CYCLES     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_speed,
  input  logic [31:0]       cmd_x,
  input  logic [31:0]       cmd_y,
  input  logic [31:0]       cmd_z,
  input  logic [31:0]       cmd_e0,
  input  logic [31:0]       cmd_e1,
  input  logic              flush,
  input  logic              clear_fault,
  output logic [31:0]       mv_speed,
  output logic [31:0]       mv_x,
  output logic [31:0]       mv_y,
  output logic [31:0]       mv_z,
  output logic [31:0]       mv_e0,
  output logic [31:0]       mv_e1,
  output logic              mv_start,
  input  logic              mv_finish,
  input  logic              mv_error,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W:0]   queue_level,
  output logic [31:0]       moves_done
);

  typedef struct packed {
    logic [31:0] speed, x, y, z, e0, e1;
  } move_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_FAULT} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0]     GAP_LAST = 32'(GAP_CYCLES - 1);

  state_t            state, state_nx;
  move_t             mem [DEPTH];
  move_t             cur;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       gap_cnt;
  logic              push, pop, done, err_hit, to_hit, clr_q;

`ifdef MOVE_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
  always_ff @(posedge clk) begin
    if (reset)                wd_cnt <= '0;
    else if (state == S_LOAD) wd_cnt <= '0;
    else if (state == S_RUN)  wd_cnt <= wd_cnt + 32'd1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  assign cmd_ready = (count != FULL_LVL) && (state != S_FAULT);
  // flush wins over a same-cycle push
  assign push  = cmd_valid && cmd_ready && !flush;
  assign clr_q = flush || err_hit || to_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
    err_hit  = 1'b0;
    to_hit   = 1'b0;
    case (state)
      S_IDLE:  if (count != '0 && !flush) begin pop = 1'b1; state_nx = S_LOAD; end
      S_LOAD:  state_nx = S_RUN;
      S_RUN: begin
        if (mv_error) begin
          err_hit  = 1'b1;
          state_nx = S_FAULT;
        end else if (mv_finish) begin
          done     = 1'b1;
          state_nx = S_GAP;
        end
`ifdef MOVE_SEQ_TIMEOUT_EN
        else if (wd_cnt == TIMEOUT_CYCLES - 32'd1) begin
          to_hit   = 1'b1;
          state_nx = S_FAULT;
        end
`endif
      end
      // mv_start held low here so every move gives the core a fresh rising edge
      S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
      S_FAULT: if (clear_fault) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd_speed, cmd_x, cmd_y, cmd_z, cmd_e0, cmd_e1};
  end

  always_ff @(posedge clk) begin
    if (reset || clr_q) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= '0;
      gap_cnt    <= '0;
      moves_done <= '0;
      fault_code <= 2'd0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      gap_cnt <= (state == S_GAP) ? gap_cnt + 32'd1 : 32'd0;
      if (done) moves_done <= moves_done + 32'd1;
      if (err_hit)                                   fault_code <= 2'd1;
      else if (to_hit)                               fault_code <= 2'd2;
      else if (state == S_FAULT && clear_fault)      fault_code <= 2'd0;
    end
  end

  assign mv_speed    = cur.speed;
  assign mv_x        = cur.x;
  assign mv_y        = cur.y;
  assign mv_z        = cur.z;
  assign mv_e0       = cur.e0;
  assign mv_e1       = cur.e1;
  assign mv_start    = (state == S_RUN);
  assign fault       = (state == S_FAULT);
  assign busy        = (state != S_IDLE) || (count != '0);
  assign queue_level = count;

endmodule
